// File: rtl/apb_req_arbiter_if.sv
// Requester-side and APB-side signals of the round-robin APB request arbiter.
// master = arbiter side, slave = requesters plus the APB completer.
interface apb_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rdata;
    logic                      err;
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_W-1:0]         paddr;
    logic [DATA_W-1:0]         pwdata;
    logic                      pready;
    logic [DATA_W-1:0]         prdata;

    modport master (
        input  req, req_addr, req_write, req_wdata, pready, prdata,
        output gnt, done, rdata, err, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req, req_addr, req_write, req_wdata, pready, prdata,
        input  gnt, done, rdata, err, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB completer between NUM_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic               pclk,
    input logic               prst,
    apb_req_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic               found;
    logic [IDX_W-1:0]   win;
    logic [ADDR_W-1:0]  win_addr;
    logic               win_write;
    logic [DATA_W-1:0]  win_wdata;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    assign bus.err = 1'b0;
`endif

    // Round-robin pick: first requesting index after last_grant, wrapping.
    always_comb begin
        int j;
        found     = 1'b0;
        win       = '0;
        win_addr  = '0;
        win_write = 1'b0;
        win_wdata = '0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(last_grant) + 1 + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && bus.req[j]) begin
                found     = 1'b1;
                win       = IDX_W'(j);
                win_addr  = bus.req_addr[j*ADDR_W +: ADDR_W];
                win_write = bus.req_write[j];
                win_wdata = bus.req_wdata[j*DATA_W +: DATA_W];
            end
        end
    end

    // Transfer FSM; every output is a register updated with the state.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state       <= IDLE;
            last_grant  <= IDX_W'(NUM_REQ - 1);
            bus.gnt     <= '0;
            bus.done    <= '0;
            bus.rdata   <= '0;
            bus.psel    <= 1'b0;
            bus.penable <= 1'b0;
            bus.pwrite  <= 1'b0;
            bus.paddr   <= '0;
            bus.pwdata  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            bus.err     <= 1'b0;
            tmo_cnt     <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state      <= SETUP;
                        last_grant <= win;
                        bus.gnt    <= NUM_REQ'(1) << win;
                        bus.psel   <= 1'b1;
                        bus.paddr  <= win_addr;
                        bus.pwrite <= win_write;
                        bus.pwdata <= win_wdata;
`ifdef APB_ARB_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    bus.penable <= 1'b1;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        state       <= DONE;
                        bus.psel    <= 1'b0;
                        bus.penable <= 1'b0;
                        bus.done    <= bus.gnt;
                        if (!bus.pwrite) bus.rdata <= bus.prdata;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state       <= DONE;
                        bus.psel    <= 1'b0;
                        bus.penable <= 1'b0;
                        bus.done    <= bus.gnt;
                        bus.rdata   <= '0;
                        bus.err     <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state    <= IDLE;
                    bus.gnt  <= '0;
                    bus.done <= '0;
`ifdef APB_ARB_TIMEOUT_EN
                    bus.err  <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one APB completer (2..8) SHALL be supported.
REQ-002 Parameter ADDR_W, 5, APB address width SHALL be supported.
REQ-003 Parameter DATA_W, 32, APB data width SHALL be supported.
REQ-004 Parameter TIMEOUT_CYCLES, 16, ACCESS-cycle limit SHALL be supported; it is used only under APB_ARB_TIMEOUT_EN.
REQ-005 pclk  in  1  single clock; all logic SHALL be clocked on the rising edge.
REQ-006 prst  in  1  reset, asynchronous, active-high.
REQ-007 req  in  NUM_REQ  per-requester transfer request, level, held until that requester's done.
REQ-008 req_addr  in  NUM_REQ*ADDR_W  per-requester address, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-009 req_write  in  NUM_REQ  per-requester direction, 1 = write.
REQ-010 req_wdata  in  NUM_REQ*DATA_W  per-requester write data, packed as req_addr.
REQ-011 gnt  out  NUM_REQ  one-hot grant, high from SETUP through DONE.
REQ-012 done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-013 rdata  out  DATA_W  read data of the last completed transfer.
REQ-014 err  out  1  high with done when the transfer was aborted by timeout.
REQ-015 psel, penable, pwrite  out  1 each  APB control to the completer.
REQ-016 paddr  out  ADDR_W; pwdata  out  DATA_W  APB address and write data.
REQ-017 pready  in  1; prdata  in  DATA_W  APB completer response.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, ACCESS, DONE; all outputs SHALL be registered.
REQ-019 IDLE: if any req bit high, the FSM SHALL grant one requester and enter SETUP next cycle; otherwise it SHALL stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NUM_REQ; last_grant updates on each grant.
REQ-021 On grant, addr/write/wdata of the winner SHALL be latched onto paddr/pwrite/pwdata; later changes to req_* SHALL be ignored until DONE.
REQ-022 SETUP SHALL last exactly one cycle with psel=1 and penable=0, then the FSM SHALL enter ACCESS unconditionally.
REQ-023 ACCESS SHALL drive psel=1 and penable=1, and SHALL stay in ACCESS while pready=0.
REQ-024 ACCESS with pready=1 SHALL enter DONE; for reads prdata SHALL be captured into rdata at that edge; writes SHALL leave rdata unchanged.
REQ-025 DONE SHALL last one cycle with psel=0, penable=0, and done[grant]=1, then enter IDLE; no arbitration SHALL occur in DONE.
REQ-026 Minimum transfer SHALL be 4 cycles (IDLE, SETUP, ACCESS, DONE); back-to-back grants SHALL be separated by IDLE.
REQ-027 paddr, pwrite and pwdata SHALL hold their last values in IDLE and DONE.
REQ-028 A req bit dropped while its transfer is in flight SHALL NOT abort the transfer.

Reset
REQ-029 While prst=1: state=IDLE, psel=penable=pwrite=0, paddr=pwdata=rdata=0, gnt=done=0, err=0, last_grant=NUM_REQ-1, timeout counter=0.
REQ-030 Reset asserted mid-transfer SHALL take effect immediately; no done pulse SHALL be issued for the aborted transfer.

Configuration
REQ-031 With APB_ARB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles with pready=0; reaching TIMEOUT_CYCLES SHALL force DONE with err=1 and rdata=0; the counter SHALL clear on entering SETUP.
REQ-032 Without APB_ARB_TIMEOUT_EN, err SHALL be tied 0 and ACCESS SHALL wait for pready indefinitely.

Verification
REQ-033 Single write: req[0]=1, addr=5, wdata=0xA5A5_0001, pready=1 -> psel high 2 cycles, penable 1 cycle, done[0] on cycle 4, err=0.
REQ-034 Wait states: read from req[2] with pready low 3 ACCESS cycles and prdata=0x1234_5678 -> ACCESS lasts 4 cycles; rdata=0x1234_5678 with done[2].
REQ-035 Round-robin: req=4'b1111 held from reset -> grant order 0,1,2,3,0; each gnt one-hot.
REQ-036 Input stability: req_addr[1] changed during ACCESS -> paddr keeps the value latched at grant.
REQ-037 Timeout (macro on, TIMEOUT_CYCLES=16): pready held 0 -> done plus err=1 after 16 ACCESS cycles, rdata=0; with macro off the FSM stays in ACCESS.
REQ-038 Reset mid-ACCESS: prst pulse -> psel=penable=0 immediately, no done, next req[3] is granted first after requester 0 (last_grant reset).
